// File: rtl/matrix_ascii_formatter_pkg.sv
// Shared constants, state encoding and sizing helper for the matrix-to-ASCII formatter.
package matrix_ascii_formatter_pkg;

  localparam logic [7:0] ASC_SP    = 8'h20;
  localparam logic [7:0] ASC_MINUS = 8'h2D;
  localparam logic [7:0] ASC_ZERO  = 8'h30;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_CONV  = 3'd3,
    S_SIGN  = 3'd4,
    S_DIG   = 3'd5,
    S_SEP   = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  // Decimal digits needed for 2^data_w - 1: floor(data_w*log10(2)) + 1.
  function automatic int ndig_for(input int data_w);
    return (data_w * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/matrix_ascii_formatter_if.sv
// Control, storage-read and byte-stream signals of the formatter, grouped for port connection.
interface matrix_ascii_formatter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DIM_W  = 3,
  parameter int CNT_W  = 2
);
  logic              i_start;
  logic [ADDR_W-1:0] i_base_addr;
  logic [DIM_W-1:0]  i_dim_m;
  logic [DIM_W-1:0]  i_dim_n;
  logic [CNT_W-1:0]  i_mat_cnt;
  logic              o_rd_en;
  logic [ADDR_W-1:0] o_rd_addr;
  logic [DATA_W-1:0] i_rd_data;
  logic [7:0]        o_tx_data;
  logic              o_tx_valid;
  logic              i_tx_ready;
  logic              o_busy;
  logic              o_done;

  modport master (
    input  i_start, i_base_addr, i_dim_m, i_dim_n, i_mat_cnt, i_rd_data, i_tx_ready,
    output o_rd_en, o_rd_addr, o_tx_data, o_tx_valid, o_busy, o_done
  );

  modport slave (
    output i_start, i_base_addr, i_dim_m, i_dim_n, i_mat_cnt, i_rd_data, i_tx_ready,
    input  o_rd_en, o_rd_addr, o_tx_data, o_tx_valid, o_busy, o_done
  );
endinterface

// File: rtl/matrix_ascii_formatter_bcd.sv
// Sequential double-dabble: binary to packed BCD in DATA_W iterations.
// The first iteration is folded into the load, so done rises DATA_W-1 cycles after start.
module bcd_dabble_seq #(
  parameter int DATA_W = 32,
  parameter int NDIG   = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DATA_W-1:0]   bin,
  output logic                busy,
  output logic                done,
  output logic [NDIG*4-1:0]   bcd
);
  localparam int CW = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] shift_r;
  logic [NDIG*4-1:0] bcd_r;
  logic [NDIG*4-1:0] adj_s;
  logic [CW-1:0]     cnt_r;
  logic              busy_r;
  logic              done_r;

  // Add-3 correction on every nibble that is 5 or more before the next shift.
  always_comb begin
    adj_s = bcd_r;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_r[4*i +: 4] >= 4'd5) begin
        adj_s[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
      end else begin
        adj_s[4*i +: 4] = bcd_r[4*i +: 4];
      end
    end
  end

  // Load, shift and iteration count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_r <= '0;
      bcd_r   <= '0;
      cnt_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else if (start) begin
      shift_r <= bin << 1;
      bcd_r   <= {{(NDIG*4-1){1'b0}}, bin[DATA_W-1]};
      cnt_r   <= CW'(DATA_W - 1);
      busy_r  <= (DATA_W > 1);
      done_r  <= (DATA_W == 1);
    end else if (busy_r) begin
      bcd_r   <= {adj_s[NDIG*4-2:0], shift_r[DATA_W-1]};
      shift_r <= shift_r << 1;
      cnt_r   <= cnt_r - CW'(1);
      if (cnt_r == CW'(1)) begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign bcd  = bcd_r;
endmodule

// File: rtl/matrix_ascii_formatter.sv
// Walks m x n matrices in storage, converts each element to decimal ASCII and streams
// the bytes with space/CRLF separators over a valid/ready handshake.
module matrix_ascii_formatter
  import matrix_ascii_formatter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DIM_W  = 3,
  parameter int CNT_W  = 2,
  parameter int NDIG   = ndig_for(DATA_W),
  parameter bit SIGNED = 1'b1
) (
  input logic clk,
  input logic rst,
  matrix_ascii_formatter_if.master bus
);
  localparam int IDX_W = $clog2(NDIG + 1);

  state_t            state_r;
  logic [DIM_W-1:0]  m_r, n_r, row_r, col_r;
  logic [CNT_W-1:0]  cnt_r, mat_r;
  logic [ADDR_W-1:0] addr_r;
  logic              neg_r;
  logic [IDX_W-1:0]  dig_r;
  logic [1:0]        sep_r;
  logic              rd_en_r, tx_valid_r, busy_r, done_r;
  logic [7:0]        tx_data_r;

  logic              dab_start_s, dab_busy_s, dab_done_s;
  logic [DATA_W:0]   neg_wide_s;
  logic [DATA_W-1:0] mag_s;
  logic [NDIG*4-1:0] bcd_s;
  logic [IDX_W-1:0]  lead_s;
  logic              last_col_s, last_row_s, last_mat_s;
  logic [1:0]        sep_last_s;

  function automatic logic [7:0] digit_char(input logic [NDIG*4-1:0] b, input logic [IDX_W-1:0] idx);
    return ASC_ZERO + {4'd0, b[4*idx +: 4]};
  endfunction

  // Negation is done one bit wider so the most-negative element yields its true magnitude.
  always_comb begin
    neg_wide_s = {(DATA_W+1){1'b0}} - {bus.i_rd_data[DATA_W-1], bus.i_rd_data};
    if (SIGNED && bus.i_rd_data[DATA_W-1]) begin
      mag_s = DATA_W'(neg_wide_s);
    end else begin
      mag_s = bus.i_rd_data;
    end
  end

  // Most significant non-zero digit; a zero value still prints digit 0.
  always_comb begin
    lead_s = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_s[4*i +: 4] != 4'd0) begin
        lead_s = IDX_W'(i);
      end else begin
        lead_s = lead_s;
      end
    end
  end

  // Position flags and length of the separator run after the current element.
  always_comb begin
    last_col_s = (col_r == n_r - DIM_W'(1));
    last_row_s = (row_r == m_r - DIM_W'(1));
    last_mat_s = (mat_r == cnt_r - CNT_W'(1));
    if (!last_col_s) begin
      sep_last_s = 2'd0;
    end else if (last_row_s && !last_mat_s) begin
      sep_last_s = 2'd3;
    end else begin
      sep_last_s = 2'd1;
    end
  end

  assign dab_start_s = (state_r == S_WAIT) && !dab_busy_s;

  bcd_dabble_seq #(.DATA_W(DATA_W), .NDIG(NDIG)) u_dabble (
    .clk   (clk),
    .rst   (rst),
    .start (dab_start_s),
    .bin   (mag_s),
    .busy  (dab_busy_s),
    .done  (dab_done_s),
    .bcd   (bcd_s)
  );

  // Main sequencer with registered read, byte and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_IDLE;
      m_r        <= '0;
      n_r        <= '0;
      row_r      <= '0;
      col_r      <= '0;
      cnt_r      <= '0;
      mat_r      <= '0;
      addr_r     <= '0;
      neg_r      <= 1'b0;
      dig_r      <= '0;
      sep_r      <= 2'd0;
      rd_en_r    <= 1'b0;
      tx_valid_r <= 1'b0;
      tx_data_r  <= 8'h00;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (bus.i_start) begin
            m_r    <= bus.i_dim_m;
            n_r    <= bus.i_dim_n;
            cnt_r  <= bus.i_mat_cnt;
            addr_r <= bus.i_base_addr;
            row_r  <= '0;
            col_r  <= '0;
            mat_r  <= '0;
            if (bus.i_dim_m == '0 || bus.i_dim_n == '0 || bus.i_mat_cnt == '0) begin
              state_r <= S_DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= S_FETCH;
              busy_r  <= 1'b1;
              rd_en_r <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          rd_en_r <= 1'b0;
          state_r <= S_WAIT;
        end
        S_WAIT: begin
          neg_r   <= SIGNED && bus.i_rd_data[DATA_W-1];
          state_r <= S_CONV;
        end
        S_CONV: begin
          if (dab_done_s) begin
            dig_r      <= lead_s;
            tx_valid_r <= 1'b1;
            if (neg_r) begin
              tx_data_r <= ASC_MINUS;
              state_r   <= S_SIGN;
            end else begin
              tx_data_r <= digit_char(bcd_s, lead_s);
              state_r   <= S_DIG;
            end
          end
        end
        S_SIGN: begin
          if (bus.i_tx_ready) begin
            tx_data_r <= digit_char(bcd_s, dig_r);
            state_r   <= S_DIG;
          end
        end
        S_DIG: begin
          if (bus.i_tx_ready) begin
            if (dig_r == '0) begin
              sep_r     <= 2'd0;
              tx_data_r <= last_col_s ? ASC_CR : ASC_SP;
              state_r   <= S_SEP;
            end else begin
              dig_r     <= dig_r - IDX_W'(1);
              tx_data_r <= digit_char(bcd_s, dig_r - IDX_W'(1));
            end
          end
        end
        S_SEP: begin
          if (bus.i_tx_ready) begin
            if (sep_r == sep_last_s) begin
              tx_valid_r <= 1'b0;
              if (last_col_s && last_row_s && last_mat_s) begin
                state_r <= S_DONE;
                done_r  <= 1'b1;
                busy_r  <= 1'b0;
              end else begin
                state_r <= S_FETCH;
                rd_en_r <= 1'b1;
                addr_r  <= addr_r + ADDR_W'(1);
                if (!last_col_s) begin
                  col_r <= col_r + DIM_W'(1);
                end else begin
                  col_r <= '0;
                  if (!last_row_s) begin
                    row_r <= row_r + DIM_W'(1);
                  end else begin
                    row_r <= '0;
                    mat_r <= mat_r + CNT_W'(1);
                  end
                end
              end
            end else begin
              sep_r     <= sep_r + 2'd1;
              tx_data_r <= sep_r[0] ? ASC_CR : ASC_LF;
            end
          end
        end
        S_DONE: begin
          done_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_rd_en    = rd_en_r;
  assign bus.o_rd_addr  = addr_r;
  assign bus.o_tx_data  = tx_data_r;
  assign bus.o_tx_valid = tx_valid_r;
  assign bus.o_busy     = busy_r;
  assign bus.o_done     = done_r;
endmodule

// File: doc/matrix_ascii_formatter.md
Name: matrix_ascii_formatter

Overview:
- Parametrised successor of the fixed-format display path.
- Reads one or more m×n matrices from synchronous storage and converts each element to signed or unsigned multi-digit decimal ASCII.
- Streams the result as bytes over a valid/ready handshake to the UART TX.
- Sits between the FSM controller (start, base, dims, count) and the UART transmitter; its read port replaces the display address input of the storage mux.

Parameters:
- DATA_W, 32, element width in bits.
- ADDR_W, 8, storage address width.
- DIM_W, 3, width of the m/n dimension inputs.
- CNT_W, 2, width of the matrix count input.
- NDIG, 10, BCD digit count; must satisfy 10^NDIG > 2^DATA_W.
- SIGNED, 1, 1 = two's-complement elements, 0 = unsigned.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- i_start  in  1  one-cycle start request; ignored while o_busy=1
- i_base_addr  in  ADDR_W  address of element (0,0) of the first matrix
- i_dim_m  in  DIM_W  rows
- i_dim_n  in  DIM_W  columns
- i_mat_cnt  in  CNT_W  number of matrices, stored back to back (stride m*n)
- o_rd_en  out  1  storage read strobe
- o_rd_addr  out  ADDR_W  storage read address
- i_rd_data  in  DATA_W  storage data, valid the cycle after o_rd_en
- o_tx_data  out  8  ASCII byte
- o_tx_valid  out  1  o_tx_data valid
- i_tx_ready  in  1  sink accepts the byte when valid&&ready
- o_busy  out  1  high from the start-accept cycle to the done cycle
- o_done  out  1  one-cycle completion pulse

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high (rst).
- Reset values:
  - All outputs 0 (o_rd_addr=0, o_tx_data=0).
  - State IDLE; all counters 0.
  - Reset mid-operation aborts immediately; no further bytes are sent.
- Start:
  - In IDLE, i_start latches base, m, n and cnt into internal registers; later input changes have no effect.
  - If m==0, n==0 or cnt==0: go to DONE next cycle, no reads, no bytes.
- States and transitions:
  - IDLE -> FETCH on accepted start.
  - FETCH: drive o_rd_en=1, o_rd_addr=cur_addr for 1 cycle -> WAIT.
  - WAIT: capture i_rd_data.
    - SIGNED and MSB=1: magnitude = two's-complement negation, computed in DATA_W+1 bits so the most-negative value converts correctly; set neg flag.
    - Then -> CONV.
  - CONV: double-dabble, exactly DATA_W cycles (add-3 on nibbles >=5, then shift) -> SIGN.
  - SIGN: if neg, emit '-' (0x2D). Then -> DIG.
  - DIG:
    - Emit BCD digits most-significant first, as '0'+digit.
    - Leading zeros are suppressed; value 0 emits a single '0'.
    - After the last digit -> SEP.
  - SEP:
    - Not last column: emit ' ' (0x20), then next element -> FETCH.
    - Last column: emit 0x0D then 0x0A.
    - After the last row of a matrix that is not the last matrix: emit an extra 0x0D 0x0A.
    - Then -> FETCH, or DONE after the last element of the last matrix.
  - DONE: o_done=1 for one cycle, o_busy=0 in the same cycle -> IDLE.
- Byte handshake:
  - Every emit state holds o_tx_valid=1 with o_tx_data stable until a cycle with i_tx_ready=1.
  - It advances in the cycle after acceptance.
  - Valid never drops without acceptance.
  - Zero-wait ready gives 1 byte/cycle.
- Addressing:
  - cur_addr starts at base and increments by 1 per element across rows and matrices.
  - Wraps modulo 2^ADDR_W.
  - Row and column counters are reset per matrix.
- Latency:
  - First byte valid on cycle start+3+DATA_W (FETCH, WAIT, CONV×DATA_W, then emit).
  - Per element: 2 + DATA_W + bytes cycles with ready held high.
- Simultaneous events: i_start in the DONE cycle is ignored; a new start is accepted only in IDLE.

Decomposition:
- Shared package holds:
  - the ASCII constants (0x20, 0x2D, 0x30, 0x0D, 0x0A);
  - the state enumeration localparams;
  - a function computing the required NDIG from DATA_W.
- One sub-module: bcd_dabble_seq (start/busy/done; DATA_W in, NDIG×4 out; DATA_W-cycle sequential double-dabble).

Test Plan:
- 2×3, cnt=1, base=0x00, data 4..9, ready=1 -> byte stream "4 5 6\r\n7 8 9\r\n"; exactly 6 reads at addresses 0..5; one o_done pulse.
- SIGNED=1, 1×3, data {0, -7, 0x80000000} -> "0 -7 -2147483648\r\n".
- 1×1, cnt=2, base=0xFF, data {12, 345} -> "12\r\n\r\n345\r\n"; read addresses 0xFF then 0x00 (wrap).
- i_tx_ready toggling 1 cycle high / 3 cycles low -> o_tx_data stable while valid&&!ready; output identical to the ready=1 run.
- m=0 start -> o_done at start+1 with zero bytes and zero reads; i_start pulsed while busy -> ignored, output unchanged.
- rst asserted mid-DIG -> all outputs 0 asynchronously; a fresh start then produces the full correct stream.
